// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter between the CPU MEM stage
// and the debug/loader port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        FORCE = 2'd1,
        LOCK  = 2'd2
    } arb_state_e;

    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_LOCK_MAX = 64;

    // Width of a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and data-memory signals of the arbiter.
// slave = arbiter view, master = surrounding pipeline/loader/memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_valid;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output dm_we, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  dm_we, dm_addr, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/dmem_arb_fsm.sv
// Ownership FSM: CPU-priority arbitration, DBG starvation escape (FORCE) and bounded
// exclusive DBG ownership (LOCK).
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic dbg_valid,
    input  logic dbg_lock,
    output logic grant_cpu,
    output logic grant_dbg
);
    localparam int WAIT_W = cnt_width(MAX_WAIT);
    localparam int LOCK_W = cnt_width(LOCK_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

    arb_state_e        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            wait_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            lock_cnt <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        lock_nxt  = '0;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        unique case (state)
            ARB: begin
                grant_cpu = cpu_req;
                grant_dbg = !cpu_req && dbg_valid;
                if (grant_dbg) begin
                    if (dbg_lock) state_nxt = LOCK;
                end else if (dbg_valid) begin
                    if (wait_cnt == WAIT_LAST) state_nxt = FORCE;
                    else                       wait_nxt  = wait_cnt + 1'b1;
                end
            end
            FORCE: begin
                grant_dbg = dbg_valid;
                state_nxt = (dbg_valid && dbg_lock) ? LOCK : ARB;
            end
            LOCK: begin
                // Memory stays owned by DBG even on idle cycles until release or timeout.
                grant_dbg = dbg_valid;
                if (!dbg_lock || lock_cnt == LOCK_LAST) state_nxt = ARB;
                else                                     lock_nxt  = lock_cnt + 1'b1;
            end
            default: state_nxt = ARB;
        endcase
        if (!rst) begin
            grant_cpu = 1'b0;
            grant_dbg = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter top: routes the granted port onto the single-port memory and
// registers DBG read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    logic grant_cpu;
    logic grant_dbg;
    logic dbg_addr_lsb_unused;

    dmem_arb_fsm #(
        .MAX_WAIT (MAX_WAIT),
        .LOCK_MAX (LOCK_MAX)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (bus.cpu_req),
        .dbg_valid (bus.dbg_valid),
        .dbg_lock  (bus.dbg_lock),
        .grant_cpu (grant_cpu),
        .grant_dbg (grant_dbg)
    );

    // DBG accesses are word-aligned, so its byte-offset bits never reach the memory.
    assign dbg_addr_lsb_unused = ^bus.dbg_addr[1:0];

    always_comb begin
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        if (grant_cpu) begin
            bus.dm_we    = bus.cpu_we;
            bus.dm_addr  = bus.cpu_addr;
            bus.dm_wdata = bus.cpu_wdata;
        end else if (grant_dbg) begin
            bus.dm_we    = bus.dbg_we;
            bus.dm_addr  = {bus.dbg_addr[ADDR_W-1:2], 2'b00};
            bus.dm_wdata = bus.dbg_wdata;
        end
    end

    assign bus.cpu_rdata = bus.dm_rdata;
    assign bus.cpu_stall = rst && bus.cpu_req && !grant_cpu;
    assign bus.dbg_ready = grant_dbg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= '0;
        end else begin
            bus.dbg_rvalid <= grant_dbg && !bus.dbg_we;
            if (grant_dbg && !bus.dbg_we) bus.dbg_rdata <= bus.dm_rdata;
        end
    end

endmodule
